core_exc_ctrl: RTL and testbench
================================

# core_exc_ctrl

Exception and interrupt controller for the i2d core. It sits directly upstream of the status-register file and drives its `write_sr`/`sr_in`, `write_mode`/`mode` and `write_i`/`i` controls. It arbitrates undefined-instruction, software-interrupt and external IRQ events, and saves the PC and status register on entry. It then handshakes a pipeline flush and redirects fetch to a vector; on `rfe` it restores the saved state.

## Interface
- `VEC_BASE`, default 32'h0000_0000: exception vector base address.
- `NIRQ`, default 8: number of external interrupt lines (1..32).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `irq`  in  NIRQ  level-sensitive interrupt lines; bit 0 has the highest priority.
- `sr`  in  sr_t  current status register.
- `undef`  in  1  execute-stage undefined instruction.
- `swi`  in  1  execute-stage software interrupt.
- `rfe`  in  1  execute-stage return-from-exception.
- `epc_in`  in  32  PC of the instruction in execute.
- `flush_ack`  in  1  pipeline drained or flushed.
- `flush_req`  out  1  request to flush the pipeline.
- `write_sr`  out  1  restore strobe.
- `sr_in`  out  sr_t  value to restore.
- `write_mode`  out  1  mode write strobe.
- `mode`  out  mode_t  new mode.
- `write_i`  out  1  interrupt-enable write strobe.
- `i`  out  1  new interrupt-enable value.
- `pc_load`  out  1  fetch redirect strobe.
- `pc_target`  out  32  redirect address.
- `epc`  out  32  saved PC.
- `esr`  out  sr_t  saved status register.
- `cause`  out  8  last cause code.
- `irq_ack`  out  NIRQ  one-hot acknowledge.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Cause codes: 1 = undef, 2 = swi, 3+n = `irq[n]`.
- FSM states are IDLE, FLUSH_E, ENTER, FLUSH_R and RETURN.
- IDLE event priority, evaluated each cycle:
  1. `undef`.
  2. `rfe` while `sr.mode != MODE_SVC`; this is treated as undef, cause 1.
  3. `swi`.
  4. Lowest-index set bit of `irq`, taken only when `sr.i == 1`.
  5. A legal `rfe`.
- Exception entry from IDLE:
  - Latch `epc <= epc_in`, `esr <= sr`, `cause <= code`.
  - Latch the winning IRQ index.
  - Go to FLUSH_E.
- Legal `rfe` from IDLE: go to FLUSH_R; `epc`, `esr` and `cause` are unchanged.
- FLUSH_E / FLUSH_R:
  - `flush_req = 1`.
  - On `flush_ack` go to ENTER or RETURN respectively.
  - Otherwise hold.
- ENTER, all outputs for exactly one cycle, then IDLE:
  - `write_mode = 1`, `mode = MODE_SVC`.
  - `write_i = 1`, `i = 0`.
  - `pc_load = 1`, `pc_target = VEC_BASE + {cause, 2'b00}`, a 32-bit add with wrap-around ignored.
  - For IRQ causes only, the corresponding `irq_ack` bit is pulsed.
- RETURN, all outputs for exactly one cycle, then IDLE:
  - `write_sr = 1`, `sr_in = esr`.
  - `pc_load = 1`, `pc_target = epc`.
- No nesting: `undef`, `swi`, `rfe` and `irq` are ignored while `busy`. Execute stalls on `busy`, so `undef`/`swi` are re-presented. IRQ levels are re-sampled in IDLE.
- `irq` and a legal `rfe` in the same cycle: the IRQ wins, and `epc = epc_in` so the `rfe` re-executes after the handler.
- `irq` with `sr.i == 0` stays pending and is not acknowledged.
- `flush_ack` is ignored outside the FLUSH states.

## Timing
- Reset, async, active-low:
  - State is IDLE.
  - Every output is 0, including `epc`, `esr`, `cause`, `sr_in`, `mode` (`MODE_USR` = 0) and `pc_target`.
  - Reset mid-operation aborts without any strobe.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to strobes.
- Event sampled at edge N:
  - `busy` and `flush_req` go high after edge N.
  - `flush_ack` sampled high at edge M: strobes are valid for the cycle after M, then IDLE.
  - Minimum event-to-strobe time is 2 cycles (ack sampled at the first edge with `flush_req` high).
- `epc`, `esr` and `cause` are stable from the cycle after N until the next entry.
- A new event is accepted in the first IDLE cycle after ENTER or RETURN. `sr` is already updated by the status-register file by then.

## Structure
- `i2d_core_defines.sv` holds:
  - `sr_t`, `mode_t`, `flag_t`.
  - `MODE_USR` and `MODE_SVC`.
  - Cause constants `EXC_UNDEF`, `EXC_SWI` and `EXC_IRQ_BASE`.
  - The state enum `exc_state_t`.
- One natural sub-module, `core_irq_prio`: a combinational priority encoder over `irq` that outputs valid, index and one-hot.

## Test plan
- After reset: every output is 0. `swi` with `epc_in = 0x100` and `flush_ack` high from the first request gives:
  - `pc_target = 0x08`, `mode = MODE_SVC`, `i = 0` two cycles after the event.
  - `epc = 0x100`, `cause = 2`.
- `irq = 8'b0000_0110`, `sr.i = 1`: `cause = 4`, `pc_target = 0x10`, `irq_ack = 8'b0000_0010` for one cycle. With `sr.i = 0` there is no response.
- `undef` and `swi` together, `flush_ack` delayed 5 cycles: `flush_req` is held for 5 cycles, `cause = 1`, `pc_target = 0x04`. `irq` raised during FLUSH is ignored.
- Legal `rfe` in SVC after entry with a saved `sr`: `write_sr = 1`, `sr_in` equals the saved value, `pc_target` equals the saved `epc`. `rfe` in USR mode is taken as undef with `cause = 1`.
- Reset asserted during FLUSH_E: all outputs 0 immediately, no strobes, and the next `swi` is handled normally.

Source files
------------

// File: rtl/i2d_core_defines.sv
// Shared i2d core types: status register layout, processor modes, exception causes
// and the exception controller state encoding.
package i2d_core_defines;

    typedef enum logic [1:0] {
        MODE_USR = 2'd0,
        MODE_SVC = 2'd1
    } mode_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flag_t;

    typedef struct packed {
        flag_t flags;
        logic  i;
        mode_t mode;
    } sr_t;

    localparam logic [7:0] EXC_UNDEF    = 8'd1;
    localparam logic [7:0] EXC_SWI      = 8'd2;
    localparam logic [7:0] EXC_IRQ_BASE = 8'd3;

    // Wide enough to index up to 32 interrupt lines.
    localparam int unsigned IRQ_IDX_W = 5;

    typedef enum logic [2:0] {
        StIdle,
        StFlushE,
        StEnter,
        StFlushR,
        StReturn
    } exc_state_t;

endpackage

// File: rtl/core_irq_prio.sv
// Combinational priority encoder over the interrupt lines; bit 0 has the highest priority.
module core_irq_prio
    import i2d_core_defines::*;
#(
    parameter int unsigned NIRQ = 8
) (
    input  logic [NIRQ-1:0]      irq,
    output logic                 valid,
    output logic [IRQ_IDX_W-1:0] idx,
    output logic [NIRQ-1:0]      onehot
);

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        // Scan downwards so the lowest set bit is the one left standing.
        for (int k = int'(NIRQ) - 1; k >= 0; k--) begin
            if (irq[k]) begin
                valid  = 1'b1;
                idx    = IRQ_IDX_W'(k);
                onehot = NIRQ'(1) << k;
            end
        end
    end

endmodule

// File: rtl/core_exc_ctrl.sv
// Exception/interrupt controller: arbitrates events, saves PC and SR, handshakes a
// pipeline flush, then redirects fetch to a vector or restores state on rfe.
module core_exc_ctrl
    import i2d_core_defines::*;
#(
    parameter logic [31:0] VEC_BASE = 32'h0000_0000,
    parameter int unsigned NIRQ     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  sr_t             sr,
    input  logic            undef,
    input  logic            swi,
    input  logic            rfe,
    input  logic [31:0]     epc_in,
    input  logic            flush_ack,
    output logic            flush_req,
    output logic            write_sr,
    output sr_t             sr_in,
    output logic            write_mode,
    output mode_t           mode,
    output logic            write_i,
    output logic            i,
    output logic            pc_load,
    output logic [31:0]     pc_target,
    output logic [31:0]     epc,
    output sr_t             esr,
    output logic [7:0]      cause,
    output logic [NIRQ-1:0] irq_ack,
    output logic            busy
);

    exc_state_t state_q, state_d;
    logic [31:0] epc_q, epc_d;
    sr_t esr_q, esr_d;
    logic [7:0] cause_q, cause_d;
    logic [NIRQ-1:0] irq_sel_q, irq_sel_d;

    logic                 prio_valid;
    logic [IRQ_IDX_W-1:0] prio_idx;
    logic [NIRQ-1:0]      prio_onehot;

    logic       enter;
    logic [7:0] code;
    logic       rfe_bad;

    core_irq_prio #(
        .NIRQ(NIRQ)
    ) u_prio (
        .irq   (irq),
        .valid (prio_valid),
        .idx   (prio_idx),
        .onehot(prio_onehot)
    );

    assign rfe_bad = rfe && (sr.mode != MODE_SVC);

    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        esr_d     = esr_q;
        cause_d   = cause_q;
        irq_sel_d = irq_sel_q;
        enter     = 1'b0;
        code      = 8'd0;
        unique case (state_q)
            StIdle: begin
                if (undef || rfe_bad) begin
                    enter = 1'b1;
                    code  = EXC_UNDEF;
                end else if (swi) begin
                    enter = 1'b1;
                    code  = EXC_SWI;
                end else if (prio_valid && sr.i) begin
                    enter = 1'b1;
                    code  = EXC_IRQ_BASE + 8'(prio_idx);
                end else if (rfe) begin
                    state_d = StFlushR;
                end
                if (enter) begin
                    state_d   = StFlushE;
                    epc_d     = epc_in;
                    esr_d     = sr;
                    cause_d   = code;
                    // Only an IRQ win leaves a line to acknowledge.
                    irq_sel_d = (code >= EXC_IRQ_BASE) ? prio_onehot : '0;
                end
            end
            StFlushE: if (flush_ack) state_d = StEnter;
            StFlushR: if (flush_ack) state_d = StReturn;
            StEnter:  state_d = StIdle;
            StReturn: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            epc_q     <= '0;
            esr_q     <= '0;
            cause_q   <= '0;
            irq_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            esr_q     <= esr_d;
            cause_q   <= cause_d;
            irq_sel_q <= irq_sel_d;
        end
    end

    always_comb begin
        flush_req  = 1'b0;
        write_sr   = 1'b0;
        sr_in      = '0;
        write_mode = 1'b0;
        mode       = MODE_USR;
        write_i    = 1'b0;
        i          = 1'b0;
        pc_load    = 1'b0;
        pc_target  = '0;
        irq_ack    = '0;
        unique case (state_q)
            StFlushE, StFlushR: flush_req = 1'b1;
            StEnter: begin
                write_mode = 1'b1;
                mode       = MODE_SVC;
                write_i    = 1'b1;
                pc_load    = 1'b1;
                pc_target  = VEC_BASE + {22'd0, cause_q, 2'b00};
                irq_ack    = irq_sel_q;
            end
            StReturn: begin
                write_sr  = 1'b1;
                sr_in     = esr_q;
                pc_load   = 1'b1;
                pc_target = epc_q;
            end
            default: ;
        endcase
    end

    assign epc   = epc_q;
    assign esr   = esr_q;
    assign cause = cause_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_core_exc_ctrl.sv
// Randomised scoreboard bench for core_exc_ctrl against a transaction-level reference model.
module tb_core_exc_ctrl;
    import i2d_core_defines::*;

    localparam logic [31:0] VEC_BASE = 32'h0000_0000;
    localparam int unsigned NIRQ     = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq;
    sr_t             sr;
    logic            undef, swi, rfe, flush_ack;
    logic [31:0]     epc_in;
    logic            flush_req, write_sr, write_mode, write_i, i, pc_load, busy;
    sr_t             sr_in, esr;
    mode_t           mode;
    logic [31:0]     pc_target, epc;
    logic [7:0]      cause;
    logic [NIRQ-1:0] irq_ack;

    core_exc_ctrl #(
        .VEC_BASE(VEC_BASE),
        .NIRQ    (NIRQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .sr        (sr),
        .undef     (undef),
        .swi       (swi),
        .rfe       (rfe),
        .epc_in    (epc_in),
        .flush_ack (flush_ack),
        .flush_req (flush_req),
        .write_sr  (write_sr),
        .sr_in     (sr_in),
        .write_mode(write_mode),
        .mode      (mode),
        .write_i   (write_i),
        .i         (i),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .epc       (epc),
        .esr       (esr),
        .cause     (cause),
        .irq_ack   (irq_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ret;
        logic [31:0] pc_target;
        sr_t         sr_in;
        logic [7:0]  irq_ack;
        logic [31:0] epc;
        sr_t         esr;
        logic [7:0]  cause;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model of the saved architectural state.
    logic [31:0] m_epc   = '0;
    sr_t         m_esr   = '0;
    logic [7:0]  m_cause = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({flush_req, write_sr, write_mode, write_i, i, pc_load, busy,
                                   mode, sr_in, irq_ack}), 64'd0);
        check({tag, "_pc_epc"}, {pc_target, epc}, 64'd0);
        check({tag, "_esr_cause"}, 64'({esr, cause}), 64'd0);
    endtask

    function automatic sr_t mk_sr(input logic [3:0] f, input logic ie, input logic svc);
        sr_t s;
        s.flags = f;
        s.i     = ie;
        s.mode  = svc ? MODE_SVC : MODE_USR;
        return s;
    endfunction

    // Monitor: every strobe cycle must match the oldest predicted response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (pc_load || write_sr || write_mode || write_i || irq_ack != '0)) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got pc_load=%0b write_sr=%0b, expected none",
                             pc_load, write_sr);
                end else begin
                    e = sb_q.pop_front();
                    check("write_sr", 64'(write_sr), 64'(e.ret));
                    check("write_mode", 64'(write_mode), 64'(!e.ret));
                    check("write_i", 64'(write_i), 64'(!e.ret));
                    check("i", 64'(i), 64'd0);
                    check("mode", 64'(mode), e.ret ? 64'(MODE_USR) : 64'(MODE_SVC));
                    check("pc_load", 64'(pc_load), 64'd1);
                    check("pc_target", 64'(pc_target), 64'(e.pc_target));
                    check("sr_in", 64'(sr_in), 64'(e.sr_in));
                    check("irq_ack", 64'(irq_ack), 64'(e.irq_ack));
                    check("epc", 64'(epc), 64'(e.epc));
                    check("esr", 64'(esr), 64'(e.esr));
                    check("cause", 64'(cause), 64'(e.cause));
                end
            end
        end
    end

    // Present one event in IDLE, predict the outcome, then walk the flush handshake.
    task automatic do_txn(input sr_t s, input logic u, input logic sw, input logic r,
                          input logic [7:0] iq, input logic [31:0] pc, input int d);
        int   code = 0;
        logic ret  = 1'b0;
        int   n    = -1;
        exp_t e;
        @(negedge clk);
        sr = s; undef = u; swi = sw; rfe = r; irq = iq; epc_in = pc;
        flush_ack = 1'($urandom);
        for (int k = 7; k >= 0; k--) if (iq[k]) n = k;
        if (u || (r && s.mode != MODE_SVC)) code = 1;
        else if (sw) code = 2;
        else if (s.i && n >= 0) code = 3 + n;
        else if (r) ret = 1'b1;
        if (code != 0) begin
            m_epc = pc; m_esr = s; m_cause = 8'(code);
            e.ret = 1'b0;
            e.pc_target = VEC_BASE + 32'(code * 4);
            e.sr_in = '0;
            e.irq_ack = (code >= 3) ? 8'(1 << (code - 3)) : 8'd0;
        end else if (ret) begin
            e.ret = 1'b1;
            e.pc_target = m_epc;
            e.sr_in = m_esr;
            e.irq_ack = '0;
        end
        e.epc = m_epc; e.esr = m_esr; e.cause = m_cause;
        if (code != 0 || ret) sb_q.push_back(e);
        @(negedge clk);
        undef = 1'b0; swi = 1'b0; rfe = 1'b0; irq = '0;
        check("busy_after_event", 64'(busy), 64'(code != 0 || ret));
        if (code != 0 || ret) begin
            for (int k = 0; k < d; k++) begin
                flush_ack = 1'b0;
                irq = 8'($urandom);
                check("flush_req_hold", 64'(flush_req), 64'd1);
                @(negedge clk);
            end
            flush_ack = 1'b1;
            irq = '0;
            check("flush_req_ack", 64'(flush_req), 64'd1);
            @(negedge clk);
            flush_ack = 1'($urandom);
            @(negedge clk);
            flush_ack = 1'b0;
            check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
            check("idle_after_strobe", 64'(busy), 64'd0);
        end else begin
            flush_ack = 1'b0;
            check("no_flush_req", 64'(flush_req), 64'd0);
        end
        check("held_epc", 64'(epc), 64'(m_epc));
        check("held_cause", 64'(cause), 64'(m_cause));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; irq = '0; sr = '0; undef = 1'b0; swi = 1'b0; rfe = 1'b0;
        epc_in = '0; flush_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        do_txn(mk_sr(4'h5, 1'b1, 1'b0), 1'b0, 1'b1, 1'b0, 8'h00, 32'h100, 0);
        do_txn(mk_sr(4'h0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 8'b0000_0110, 32'h104, 1);
        do_txn(mk_sr(4'h0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 8'b0000_0110, 32'h108, 0);
        do_txn(mk_sr(4'h3, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 8'h00, 32'h10c, 5);
        do_txn(mk_sr(4'ha, 1'b1, 1'b0), 1'b0, 1'b1, 1'b0, 8'h00, 32'h200, 2);
        do_txn(mk_sr(4'h0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1, 8'h00, 32'h300, 3);
        do_txn(mk_sr(4'h0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, 8'h00, 32'h304, 0);
        do_txn(mk_sr(4'h0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1, 8'h80, 32'h308, 0);

        // Reset while in FLUSH_E must abort silently.
        @(negedge clk);
        sr = mk_sr(4'h1, 1'b1, 1'b0); swi = 1'b1; epc_in = 32'h400; flush_ack = 1'b0;
        @(negedge clk);
        swi = 1'b0;
        check("busy_before_reset", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1 check_all_zero("mid_reset");
        m_epc = '0; m_esr = '0; m_cause = '0;
        @(negedge clk);
        check_all_zero("held_reset");
        rst = 1'b1;
        do_txn(mk_sr(4'h2, 1'b1, 1'b0), 1'b0, 1'b1, 1'b0, 8'h00, 32'h500, 0);

        for (int t = 0; t < 150; t++) begin
            do_txn(mk_sr(4'($urandom), 1'($urandom), 1'($urandom)),
                   $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) == 0,
                   ($urandom_range(0, 1) == 1) ? 8'($urandom & $urandom) : 8'h00,
                   $urandom & 32'hffff_fffc, int'($urandom_range(0, 4)));
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
